register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding when 1.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-008 SHALL have port RegWriteSig, input, 1, meaning write enable.
REQ-009 SHALL have port writeReg, input, ADDR_W, meaning write address.
REQ-010 SHALL have port writeData, input, DATA_W, meaning write data.
REQ-011 SHALL have port readRegs, input, NUM_RD*ADDR_W, meaning packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port RegDatas, output, NUM_RD*DATA_W, meaning packed read data, port i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port clearReq, input, 1, meaning request to zero all entries.
REQ-014 SHALL have port busy, output, 1, meaning clear sequence in progress.

Function
REQ-015 SHALL write writeData to entry writeReg on rising clk when RegWriteSig=1 and busy=0.
REQ-016 SHALL ignore writes to entry 0 when ZERO_REG=1.
REQ-017 SHALL drive each RegDatas port combinationally from the entry selected by its readRegs address (zero latency).
REQ-018 SHALL return 0 for address 0 when ZERO_REG=1, regardless of array contents or bypass.
REQ-019 SHALL, when BYPASS=1, busy=0, RegWriteSig=1 and readRegs[i]==writeReg (non-zero or ZERO_REG=0), drive writeData on port i in the same cycle.
REQ-020 SHALL, when BYPASS=0, return the pre-write value for a same-cycle read of the written address.
REQ-021 SHALL support all NUM_RD ports reading any addresses, including identical ones, simultaneously.
REQ-022 SHALL implement FSM states IDLE and CLEAR; IDLE→CLEAR on rising clk when clearReq=1.
REQ-023 SHALL, in CLEAR, zero one entry per cycle at a counter running 0..DEPTH-1, and return to IDLE in the cycle after entry DEPTH-1 is zeroed (exactly DEPTH cycles in CLEAR).
REQ-024 SHALL assert busy=1 exactly while in CLEAR.
REQ-025 SHALL drive all RegDatas to 0 while busy=1.
REQ-026 SHALL ignore RegWriteSig while busy=1, including the entry currently being cleared.
REQ-027 SHALL ignore clearReq while busy=1; a clearReq held high at CLEAR→IDLE starts a new sequence on the next edge.
REQ-028 SHALL perform a write presented in the same cycle as clearReq in IDLE before the clear begins; the subsequent clear zeroes it.

Reset
REQ-029 SHALL, on rst=1, immediately set all entries to 0, FSM to IDLE, counter to 0, busy=0, all RegDatas=0.
REQ-030 SHALL abort any clear sequence on rst, including mid-sequence, with no partial state retained.
REQ-031 SHALL ignore writes and clearReq while rst=1.

Structure
REQ-032 SHALL place the FSM state enumeration and parameter defaults in shared package regfile_pkg.
REQ-033 SHALL be a single module with no sub-modules; read ports generated by a generate loop over NUM_RD.

Verification
REQ-034 SHALL cover: rst pulse mid-clear at entry 10 → busy=0 immediately, all reads 0, next write of 7 to entry 10 reads back 7.
REQ-035 SHALL cover: write 50 to entry 20, then read port 1 at 20 → 50; port 0 at 0 → 0.
REQ-036 SHALL cover: write 0xDEADBEEF to entry 0 (ZERO_REG=1) → subsequent read of 0 returns 0.
REQ-037 SHALL cover: same-cycle write 123 to entry 5 with both ports reading 5 → both 123 (BYPASS=1); old value (BYPASS=0).
REQ-038 SHALL cover: fill all 32 entries, pulse clearReq → busy high exactly 32 cycles, writes during busy discarded, all entries 0 afterward.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: parameter defaults
// and the clear-sequencer state encoding.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned NUM_RD_DEF   = 2;
  localparam int unsigned ZERO_REG_DEF = 1;
  localparam int unsigned BYPASS_DEF   = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional hardwired zero entry, optional
// write-to-read forwarding, and a one-entry-per-cycle clear sequencer.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ZERO_REG = ZERO_REG_DEF,
  parameter int unsigned BYPASS   = BYPASS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWriteSig,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic [NUM_RD*ADDR_W-1:0] readRegs,
  output logic [NUM_RD*DATA_W-1:0] RegDatas,
  input  logic                     clearReq,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              user_wr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign busy    = (state_q == CLEAR);
  assign user_wr = (state_q == IDLE) && RegWriteSig &&
                   !((ZERO_REG != 0) && (writeReg == '0));

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = writeReg;
    wr_data = writeData;
    case (state_q)
      IDLE: begin
        wr_en = user_wr;
        if (clearReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the array itself is reset because reset must leave every entry reading zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign rd_addr = readRegs[g*ADDR_W +: ADDR_W];

    // Later overrides take priority: forwarding beats the array, zeroing beats both.
    always_comb begin
      rd_data = mem_q[rd_addr];
      if ((BYPASS != 0) && user_wr && (rd_addr == writeReg)) rd_data = writeData;
      if (((ZERO_REG != 0) && (rd_addr == '0)) || busy || rst) rd_data = '0;
    end

    assign RegDatas[g*DATA_W +: DATA_W] = rd_data;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one forwarding instance and one
// non-forwarding instance driven by identical stimulus.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteSig;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [9:0]  readRegs;
  logic        clearReq;
  logic [63:0] rd_a, rd_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .RegWriteSig(RegWriteSig), .writeReg(writeReg),
    .writeData(writeData), .readRegs(readRegs), .RegDatas(rd_a),
    .clearReq(clearReq), .busy(busy_a)
  );

  register_file_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .RegWriteSig(RegWriteSig), .writeReg(writeReg),
    .writeData(writeData), .readRegs(readRegs), .RegDatas(rd_b),
    .clearReq(clearReq), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    readRegs = {a1, a0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with a write and clear request pending: both must be ignored.
    rst = 1'b1; RegWriteSig = 1'b1; writeReg = 5'd3; writeData = 32'd55;
    clearReq = 1'b1; set_rd(5'd3, 5'd3);
    tick(); tick();
    check("rst_busy",     {31'd0, busy_a}, 32'd0);
    check("rst_bypass_p0", rd_a[31:0],     32'd0);
    check("rst_bypass_p1", rd_a[63:32],    32'd0);

    clearReq = 1'b0; RegWriteSig = 1'b0; rst = 1'b0;
    #1;
    check("rst_write_ignored", rd_a[31:0], 32'd0);
    tick();
    check("rst_clear_ignored", {31'd0, busy_a}, 32'd0);

    // Write 50 to entry 20; port 1 reads 20, port 0 reads 0.
    RegWriteSig = 1'b1; writeReg = 5'd20; writeData = 32'd50; set_rd(5'd0, 5'd20);
    #1;
    check("fwd_20_a_p1",   rd_a[63:32], 32'd50);
    check("nofwd_20_b_p1", rd_b[63:32], 32'd0);
    tick();
    RegWriteSig = 1'b0;
    #1;
    check("rd_20_p1", rd_a[63:32], 32'd50);
    check("rd_0_p0",  rd_a[31:0],  32'd0);
    check("rd_20_b",  rd_b[63:32], 32'd50);

    // Write to entry 0 must be dropped and never forwarded.
    RegWriteSig = 1'b1; writeReg = 5'd0; writeData = 32'hDEADBEEF; set_rd(5'd0, 5'd0);
    #1;
    check("zero_fwd_p0", rd_a[31:0], 32'd0);
    tick();
    RegWriteSig = 1'b0;
    #1;
    check("zero_after_p0", rd_a[31:0],  32'd0);
    check("zero_after_p1", rd_a[63:32], 32'd0);

    // Preload 9 at entry 5, then same-cycle write 123 with both ports on 5.
    RegWriteSig = 1'b1; writeReg = 5'd5; writeData = 32'd9;
    tick();
    writeData = 32'd123; set_rd(5'd5, 5'd5);
    #1;
    check("fwd5_a_p0", rd_a[31:0],  32'd123);
    check("fwd5_a_p1", rd_a[63:32], 32'd123);
    check("old5_b_p0", rd_b[31:0],  32'd9);
    check("old5_b_p1", rd_b[63:32], 32'd9);
    tick();
    RegWriteSig = 1'b0;
    #1;
    check("new5_b_p0", rd_b[31:0], 32'd123);

    // Fill every entry with 100+i (entry 0 stays zero).
    for (int i = 0; i < 32; i++) begin
      RegWriteSig = 1'b1; writeReg = 5'(i); writeData = 32'(100 + i);
      tick();
    end
    RegWriteSig = 1'b0; set_rd(5'd31, 5'd1);
    #1;
    check("fill_31", rd_a[31:0],  32'd131);
    check("fill_1",  rd_a[63:32], 32'd101);

    // Clear requested alongside a write to entry 7.
    RegWriteSig = 1'b1; writeReg = 5'd7; writeData = 32'd77; clearReq = 1'b1;
    set_rd(5'd7, 5'd0);
    #1;
    check("clrreq_fwd7", rd_a[31:0], 32'd77);
    tick();
    clearReq = 1'b0;
    RegWriteSig = 1'b1; writeReg = 5'd2; writeData = 32'd999; set_rd(5'd31, 5'd2);
    #1;
    check("clear_busy",   {31'd0, busy_a}, 32'd1);
    check("clear_rd31_0", rd_a[31:0],      32'd0);
    check("clear_rd2_0",  rd_a[63:32],     32'd0);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      tick();
    end
    RegWriteSig = 1'b0;
    check("busy_cycles", 32'(n), 32'd32);
    check("busy_done",   {31'd0, busy_a}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      #1;
      check($sformatf("cleared_p0_%0d", i), rd_a[31:0],  32'd0);
      check($sformatf("cleared_p1_%0d", i), rd_a[63:32], 32'd0);
    end

    // Abort a clear with reset while it is at entry 10.
    tick();
    RegWriteSig = 1'b1; writeReg = 5'd10; writeData = 32'd5;
    tick();
    writeReg = 5'd12; writeData = 32'd6;
    tick();
    RegWriteSig = 1'b0; set_rd(5'd12, 5'd10);
    #1;
    check("pre_abort_12", rd_a[31:0],  32'd6);
    check("pre_abort_10", rd_a[63:32], 32'd5);
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    repeat (10) tick();
    check("mid_clear_busy", {31'd0, busy_a}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy_a", {31'd0, busy_a}, 32'd0);
    check("abort_busy_b", {31'd0, busy_b}, 32'd0);
    check("abort_rd12",   rd_a[31:0],      32'd0);
    check("abort_rd10",   rd_a[63:32],     32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_12", rd_a[31:0], 32'd0);
    RegWriteSig = 1'b1; writeReg = 5'd10; writeData = 32'd7;
    tick();
    RegWriteSig = 1'b0; set_rd(5'd10, 5'd10);
    #1;
    check("rd10_p0", rd_a[31:0],  32'd7);
    check("rd10_p1", rd_a[63:32], 32'd7);
    tick(); tick();
    check("no_resume_busy", {31'd0, busy_a}, 32'd0);
    check("rd10_kept",      rd_b[31:0],      32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
